// File: rtl/bus_bridge_slave.sv
// Slave end of the inter-board bus bridge: serial bus slave <-> 32-bit UART request / 16-bit UART response.
// Reads release the bus with a split pulse while the UART round trip is in flight.

module uart_other #(
    parameter int CLKS          = 5208,
    parameter int TX_DATA_WIDTH = 32,
    parameter int RX_DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     tx_en,
    input  logic [TX_DATA_WIDTH-1:0] tx_data,
    output logic                     tx_busy,
    output logic                     tx,
    input  logic                     rx,
    output logic [RX_DATA_WIDTH-1:0] rx_data,
    output logic                     ready
);
    localparam int CW      = $clog2(CLKS + 1);
    localparam int TBW     = $clog2(TX_DATA_WIDTH + 3);
    localparam int RBW     = $clog2(RX_DATA_WIDTH + 3);
    localparam int HALF_M1 = (CLKS / 2 > 0) ? (CLKS / 2 - 1) : 0;

    logic                     tx_busy_r;
    logic                     tx_r;
    logic [TX_DATA_WIDTH:0]   tx_shift_r;
    logic [CW-1:0]            tx_clk_r;
    logic [TBW-1:0]           tx_bit_r;

    logic                     rx_s1_r;
    logic                     rx_s2_r;
    logic                     rx_act_r;
    logic [CW-1:0]            rx_cd_r;
    logic [RBW-1:0]           rx_bit_r;
    logic [RX_DATA_WIDTH-1:0] rx_shift_r;
    logic                     ready_r;

    assign tx_busy = tx_busy_r;
    assign tx      = tx_r;
    assign rx_data = rx_shift_r;
    assign ready   = ready_r;

    // Transmitter: start bit, TX_DATA_WIDTH data bits LSB first, stop bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_busy_r  <= 1'b0;
            tx_r       <= 1'b1;
            tx_shift_r <= {(TX_DATA_WIDTH + 1){1'b0}};
            tx_clk_r   <= {CW{1'b0}};
            tx_bit_r   <= {TBW{1'b0}};
        end else if (!tx_busy_r) begin
            if (tx_en) begin
                tx_busy_r  <= 1'b1;
                tx_r       <= 1'b0;
                tx_shift_r <= {1'b1, tx_data};
                tx_clk_r   <= {CW{1'b0}};
                tx_bit_r   <= {TBW{1'b0}};
            end
        end else if (tx_clk_r == CW'(CLKS - 1)) begin
            tx_clk_r <= {CW{1'b0}};
            if (tx_bit_r == TBW'(TX_DATA_WIDTH + 1)) begin
                tx_busy_r <= 1'b0;
                tx_r      <= 1'b1;
            end else begin
                tx_r       <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[TX_DATA_WIDTH:1]};
                tx_bit_r   <= tx_bit_r + TBW'(1);
            end
        end else begin
            tx_clk_r <= tx_clk_r + CW'(1);
        end
    end

    // Receiver: mid-bit sampling; ready drops at each start bit and rises on a good stop bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1_r    <= 1'b1;
            rx_s2_r    <= 1'b1;
            rx_act_r   <= 1'b0;
            rx_cd_r    <= {CW{1'b0}};
            rx_bit_r   <= {RBW{1'b0}};
            rx_shift_r <= {RX_DATA_WIDTH{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            rx_s1_r <= rx;
            rx_s2_r <= rx_s1_r;
            if (!rx_act_r) begin
                if (!rx_s2_r) begin
                    rx_act_r <= 1'b1;
                    rx_cd_r  <= CW'(HALF_M1);
                    rx_bit_r <= {RBW{1'b0}};
                    ready_r  <= 1'b0;
                end
            end else if (rx_cd_r != {CW{1'b0}}) begin
                rx_cd_r <= rx_cd_r - CW'(1);
            end else begin
                rx_cd_r <= CW'(CLKS - 1);
                if (rx_bit_r == {RBW{1'b0}}) begin
                    if (rx_s2_r) begin
                        rx_act_r <= 1'b0;
                    end else begin
                        rx_bit_r <= RBW'(1);
                    end
                end else if (rx_bit_r == RBW'(RX_DATA_WIDTH + 1)) begin
                    rx_act_r <= 1'b0;
                    ready_r  <= rx_s2_r;
                end else begin
                    rx_shift_r <= {rx_s2_r, rx_shift_r[RX_DATA_WIDTH-1:1]};
                    rx_bit_r   <= rx_bit_r + RBW'(1);
                end
            end
        end
    end
endmodule

module bus_bridge_slave #(
    parameter int DATA_WIDTH            = 8,
    parameter int ADDR_WIDTH            = 16,
    parameter int SLAVE_MEM_ADDR_WIDTH  = 12,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int RESP_TIMEOUT          = 2000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sready,
    output logic ssplit,
    input  logic split_grant,
    output logic u_tx,
    input  logic u_rx
);
    localparam int TXW      = 32;
    localparam int RXW      = 16;
    localparam int BCNT_MAX = (SLAVE_MEM_ADDR_WIDTH > DATA_WIDTH) ? SLAVE_MEM_ADDR_WIDTH : DATA_WIDTH;
    localparam int BW       = $clog2(BCNT_MAX + 1);
    localparam int TW       = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_WDATA      = 3'd2,
        ST_SEND       = 3'd3,
        ST_WAIT_TX    = 3'd4,
        ST_WAIT_RX    = 3'd5,
        ST_SPLIT_WAIT = 3'd6,
        ST_RDATA      = 3'd7
    } state_t;

    state_t                          state_r;
    state_t                          state_nx;
    logic                            mode_r;
    logic [SLAVE_MEM_ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0]           wdata_r;
    logic [DATA_WIDTH-1:0]           rdata_r;
    logic [BW-1:0]                   bcnt_r;
    logic [TW-1:0]                   tout_r;
    logic                            tx_seen_r;
    logic                            rx_ready_prev_r;

    logic                            tx_busy_s;
    logic [TXW-1:0]                  tx_frame_s;
    logic [RXW-1:0]                  rx_data_s;
    logic                            rx_ready_s;
    logic                            rx_pulse_s;
    logic                            unused_rx_s;
    logic                            addr_last_s;
    logic                            wdata_last_s;
    logic                            timeout_s;

    logic sready_r, svalid_r, srdata_r, ssplit_r, u_en_r;
    logic sready_nx, svalid_nx, srdata_nx, ssplit_nx, u_en_nx;

    assign tx_frame_s   = {{(TXW - 1 - DATA_WIDTH - ADDR_WIDTH){1'b0}}, mode_r, wdata_r,
                           {(ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH){1'b0}}, addr_r};
    assign rx_pulse_s   = rx_ready_s & ~rx_ready_prev_r;
    assign unused_rx_s  = ^rx_data_s[RXW-1:DATA_WIDTH];
    assign addr_last_s  = (bcnt_r == BW'(SLAVE_MEM_ADDR_WIDTH - 1));
    assign wdata_last_s = (bcnt_r == BW'(DATA_WIDTH - 1));
    assign timeout_s    = (tout_r == TW'(RESP_TIMEOUT - 1));

    assign sready = sready_r;
    assign svalid = svalid_r;
    assign srdata = srdata_r;
    assign ssplit = ssplit_r;

    uart_other #(
        .CLKS          (UART_CLOCKS_PER_PULSE),
        .TX_DATA_WIDTH (TXW),
        .RX_DATA_WIDTH (RXW)
    ) u_uart (
        .clk     (clk),
        .rstn    (rstn),
        .tx_en   (u_en_r),
        .tx_data (tx_frame_s),
        .tx_busy (tx_busy_s),
        .tx      (u_tx),
        .rx      (u_rx),
        .rx_data (rx_data_s),
        .ready   (rx_ready_s)
    );

    // State register and response-ready edge history
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r         <= ST_IDLE;
            rx_ready_prev_r <= 1'b0;
        end else begin
            state_r         <= state_nx;
            rx_ready_prev_r <= rx_ready_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE:       if (mvalid) state_nx = ST_ADDR; else state_nx = ST_IDLE;
            ST_ADDR: begin
                if (mvalid && addr_last_s) begin
                    state_nx = mode_r ? ST_WDATA : ST_SEND;
                end else begin
                    state_nx = ST_ADDR;
                end
            end
            ST_WDATA:      if (mvalid && wdata_last_s) state_nx = ST_SEND; else state_nx = ST_WDATA;
            ST_SEND:       if (!tx_busy_s) state_nx = ST_WAIT_TX; else state_nx = ST_SEND;
            ST_WAIT_TX: begin
                if (tx_seen_r && !tx_busy_s) begin
                    state_nx = mode_r ? ST_IDLE : ST_WAIT_RX;
                end else begin
                    state_nx = ST_WAIT_TX;
                end
            end
            ST_WAIT_RX:    if (rx_pulse_s || timeout_s) state_nx = ST_SPLIT_WAIT; else state_nx = ST_WAIT_RX;
            ST_SPLIT_WAIT: if (split_grant) state_nx = ST_RDATA; else state_nx = ST_SPLIT_WAIT;
            ST_RDATA:      if (bcnt_r == BW'(DATA_WIDTH)) state_nx = ST_IDLE; else state_nx = ST_RDATA;
            default:       state_nx = ST_IDLE;
        endcase
    end

    // Output decode; every bus-facing output is registered below
    always_comb begin
        sready_nx = (state_nx == ST_IDLE);
        ssplit_nx = 1'b0;
        u_en_nx   = 1'b0;
        svalid_nx = 1'b0;
        srdata_nx = 1'b0;
        case (state_r)
            ST_SEND:    u_en_nx   = !tx_busy_s;
            ST_WAIT_TX: ssplit_nx = tx_seen_r && !tx_busy_s && !mode_r;
            ST_SPLIT_WAIT: begin
                if (split_grant) begin
                    svalid_nx = 1'b1;
                    srdata_nx = rdata_r[0];
                end else begin
                    svalid_nx = 1'b0;
                    srdata_nx = 1'b0;
                end
            end
            ST_RDATA: begin
                if (bcnt_r != BW'(DATA_WIDTH)) begin
                    svalid_nx = 1'b1;
                    srdata_nx = rdata_r[0];
                end else begin
                    svalid_nx = 1'b0;
                    srdata_nx = 1'b0;
                end
            end
            default: begin
                svalid_nx = 1'b0;
                srdata_nx = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sready_r <= 1'b1;
            svalid_r <= 1'b0;
            srdata_r <= 1'b0;
            ssplit_r <= 1'b0;
            u_en_r   <= 1'b0;
        end else begin
            sready_r <= sready_nx;
            svalid_r <= svalid_nx;
            srdata_r <= srdata_nx;
            ssplit_r <= ssplit_nx;
            u_en_r   <= u_en_nx;
        end
    end

    // Datapath: serial shift-in, bit counting, response timeout and read-data shift-out
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_r    <= 1'b0;
            addr_r    <= {SLAVE_MEM_ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            rdata_r   <= {DATA_WIDTH{1'b0}};
            bcnt_r    <= {BW{1'b0}};
            tout_r    <= {TW{1'b0}};
            tx_seen_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mvalid) begin
                        mode_r  <= smode;
                        addr_r  <= {swdata, addr_r[SLAVE_MEM_ADDR_WIDTH-1:1]};
                        wdata_r <= {DATA_WIDTH{1'b0}};
                        bcnt_r  <= BW'(1);
                    end else begin
                        bcnt_r  <= {BW{1'b0}};
                    end
                end
                ST_ADDR: begin
                    if (mvalid) begin
                        addr_r <= {swdata, addr_r[SLAVE_MEM_ADDR_WIDTH-1:1]};
                        bcnt_r <= addr_last_s ? {BW{1'b0}} : bcnt_r + BW'(1);
                    end
                end
                ST_WDATA: begin
                    if (mvalid) begin
                        wdata_r <= {swdata, wdata_r[DATA_WIDTH-1:1]};
                        bcnt_r  <= wdata_last_s ? {BW{1'b0}} : bcnt_r + BW'(1);
                    end
                end
                ST_SEND:    tx_seen_r <= 1'b0;
                ST_WAIT_TX: begin
                    if (tx_busy_s) tx_seen_r <= 1'b1;
                    tout_r <= {TW{1'b0}};
                end
                ST_WAIT_RX: begin
                    tout_r <= tout_r + TW'(1);
                    // A response landing on the timeout cycle still wins
                    if (rx_pulse_s) begin
                        rdata_r <= rx_data_s[DATA_WIDTH-1:0];
                    end else if (timeout_s) begin
                        rdata_r <= {DATA_WIDTH{1'b1}};
                    end
                end
                ST_SPLIT_WAIT: begin
                    if (split_grant) begin
                        rdata_r <= {1'b0, rdata_r[DATA_WIDTH-1:1]};
                        bcnt_r  <= BW'(1);
                    end
                end
                ST_RDATA: begin
                    if (bcnt_r != BW'(DATA_WIDTH)) begin
                        rdata_r <= {1'b0, rdata_r[DATA_WIDTH-1:1]};
                        bcnt_r  <= bcnt_r + BW'(1);
                    end else begin
                        bcnt_r  <= {BW{1'b0}};
                    end
                end
                default: bcnt_r <= {BW{1'b0}};
            endcase
        end
    end
endmodule

// File: tb/tb_bus_bridge_slave.sv
// Directed + randomized bench for bus_bridge_slave with a bench-side UART remote and request model.
module tb_bus_bridge_slave;
    localparam int CLKS = 4;
    localparam int RT   = 2000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic swdata = 1'b0;
    logic smode = 1'b0;
    logic mvalid = 1'b0;
    logic split_grant = 1'b0;
    logic u_rx = 1'b1;
    logic srdata, svalid, sready, ssplit, u_tx;

    int checks = 0;
    int failures = 0;
    int ssplit_cnt = 0;
    logic [31:0] frames[$];

    bus_bridge_slave #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .SLAVE_MEM_ADDR_WIDTH(12),
        .UART_CLOCKS_PER_PULSE(CLKS), .RESP_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit),
        .split_grant(split_grant), .u_tx(u_tx), .u_rx(u_rx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ssplit === 1'b1) ssplit_cnt++;

    // Remote side receiver: decode start + 32 data bits + stop from u_tx
    initial begin : tx_monitor
        logic [31:0] f;
        forever begin
            @(negedge u_tx);
            repeat (CLKS / 2) @(posedge clk);
            #1;
            if (u_tx !== 1'b0) continue;
            for (int i = 0; i < 32; i++) begin
                repeat (CLKS) @(posedge clk);
                #1;
                f[i] = u_tx;
            end
            repeat (CLKS) @(posedge clk);
            #1;
            if (u_tx === 1'b1) frames.push_back(f);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_frame(input logic mode, input logic [11:0] addr, input logic [7:0] wd);
        int unsigned v;
        v = 32'(addr);
        if (mode) v = v + 32'h0100_0000 + 32'(wd) * 32'h0001_0000;
        return 32'(v);
    endfunction

    task automatic send_bus(input logic mode, input logic [11:0] addr, input logic [7:0] wd, input bit gap);
        for (int i = 0; i < 12; i++) begin
            if (gap && i == 5) begin
                mvalid = 1'b0;
                swdata = 1'($urandom_range(0, 1));
                smode  = 1'($urandom_range(0, 1));
                repeat (3) tick();
            end
            smode = mode; swdata = addr[i]; mvalid = 1'b1;
            tick();
        end
        if (mode) begin
            for (int i = 0; i < 8; i++) begin
                swdata = wd[i]; mvalid = 1'b1;
                tick();
            end
        end
        mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    endtask

    task automatic uart_send(input logic [15:0] d);
        u_rx = 1'b0;
        repeat (CLKS) tick();
        for (int i = 0; i < 16; i++) begin
            u_rx = d[i];
            repeat (CLKS) tick();
        end
        u_rx = 1'b1;
        repeat (3 * CLKS) tick();
    endtask

    task automatic wait_frame(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (frames.size() == 0 && n < 600) begin tick(); n++; end
        check({tag, "_frame_seen"}, 32'(frames.size() > 0), 32'd1);
        if (frames.size() > 0) check({tag, "_frame"}, frames.pop_front(), exp);
    endtask

    task automatic wait_ssplit(input string tag);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 600) begin
            tick(); n++;
            if (ssplit === 1'b1) seen = 1'b1;
        end
        check({tag, "_ssplit_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic grant_collect(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        int vcnt;
        got = 8'h00; vcnt = 0;
        split_grant = 1'b1;
        tick();
        split_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (svalid === 1'b1) vcnt++;
            got[i] = srdata;
            tick();
        end
        check({tag, "_rdata"}, 32'(got), 32'(exp));
        check({tag, "_valid_cycles"}, 32'(vcnt), 32'd8);
        check({tag, "_end_valid_ready"}, {30'd0, svalid, sready}, 32'd1);
    endtask

    task automatic do_write(input string tag, input logic [11:0] addr, input logic [7:0] wd, input bit gap);
        int s0, n;
        s0 = ssplit_cnt;
        send_bus(1'b1, addr, wd, gap);
        check({tag, "_busy"}, 32'(sready), 32'd0);
        wait_frame(tag, model_frame(1'b1, addr, wd));
        n = 0;
        while (sready !== 1'b1 && n < 100) begin tick(); n++; end
        check({tag, "_sready"}, 32'(sready), 32'd1);
        check({tag, "_no_split"}, 32'(ssplit_cnt), 32'(s0));
    endtask

    task automatic do_read(input string tag, input logic [11:0] addr, input logic [15:0] resp, input bit gap);
        int s0;
        s0 = ssplit_cnt;
        send_bus(1'b0, addr, 8'h00, gap);
        wait_ssplit(tag);
        wait_frame(tag, model_frame(1'b0, addr, 8'h00));
        uart_send(resp);
        repeat (4) tick();
        grant_collect(tag, resp[7:0]);
        check({tag, "_split_once"}, 32'(ssplit_cnt), 32'(s0 + 1));
    endtask

    initial begin : main
        int vseen;
        logic m;
        logic [11:0] a;
        logic [7:0] w;
        logic [15:0] r;

        // Reset state
        repeat (4) tick();
        check("reset_outputs", {27'd0, sready, svalid, srdata, ssplit, u_tx}, 32'b10001);
        rstn = 1'b1;
        tick();
        check("post_reset_outputs", {27'd0, sready, svalid, srdata, ssplit, u_tx}, 32'b10001);

        do_write("wr_5a3", 12'h5A3, 8'hC7, 1'b0);
        do_read("rd_012", 12'h012, 16'h0042, 1'b0);
        do_write("wr_gap", 12'h5A3, 8'hC7, 1'b1);

        // Stale response while idle must not leak into the next read
        uart_send(16'h1234);
        check("stale_idle", {30'd0, sready, svalid}, 32'b10);
        do_read("rd_after_stale", 12'h3C1, 16'h0099, 1'b0);

        // No response: grant before the timeout is ignored, after it data reads all-ones
        send_bus(1'b0, 12'h7E5, 8'h00, 1'b0);
        wait_ssplit("rd_tmo");
        wait_frame("rd_tmo", model_frame(1'b0, 12'h7E5, 8'h00));
        repeat (RT - 10 - 3 * CLKS * 0 - 0) tick();
        split_grant = 1'b1;
        tick();
        split_grant = 1'b0;
        vseen = 0;
        for (int i = 0; i < 3; i++) begin
            if (svalid === 1'b1) vseen++;
            tick();
        end
        check("early_grant_ignored", 32'(vseen), 32'd0);
        repeat (30) tick();
        grant_collect("rd_tmo", 8'hFF);

        // Reset while waiting for a response: the late response is dropped
        send_bus(1'b0, 12'h0F0, 8'h00, 1'b0);
        wait_ssplit("rd_rst");
        wait_frame("rd_rst", model_frame(1'b0, 12'h0F0, 8'h00));
        tick();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        check("rst_mid_ready", {30'd0, sready, svalid}, 32'b10);
        uart_send(16'h00AB);
        split_grant = 1'b1;
        tick();
        split_grant = 1'b0;
        vseen = 0;
        for (int i = 0; i < 12; i++) begin
            if (svalid === 1'b1) vseen++;
            tick();
        end
        check("rst_resp_ignored", 32'(vseen), 32'd0);
        check("rst_sready", 32'(sready), 32'd1);
        check("no_stray_frames", 32'(frames.size()), 32'd0);

        // Randomized transactions against the request/response model
        for (int t = 0; t < 6; t++) begin
            m = 1'($urandom_range(0, 1));
            a = 12'($urandom);
            w = 8'($urandom);
            r = 16'($urandom);
            if (m) do_write($sformatf("rnd%0d_wr", t), a, w, 1'($urandom_range(0, 1)));
            else   do_read($sformatf("rnd%0d_rd", t), a, r, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
